// File: rtl/uart_sim_receiver_core.sv
// uart_sim_receiver_core
//   Simulation-side 8N1 UART receiver. Watches a serial TX line, decodes bytes and
//   presents each good byte with a one-cycle valid strobe. Frames whose stop bit is
//   low are dropped with a one-cycle framing-error strobe.
//
//   Parameters:
//     CLOCK_FREQ  clk_i frequency in Hz
//     BAUD_RATE   serial bit rate; one bit lasts CLOCK_FREQ/BAUD_RATE cycles
//
//   Ports:
//     clk_i    system clock, rising edge
//     rstn_i   asynchronous reset, active low
//     txd_i    serial line, idle high
//     data_o   last correctly received byte
//     valid_o  one-cycle strobe, data_o holds a new byte
//     ferr_o   one-cycle strobe, frame dropped (stop bit low)
//     busy_o   high while a frame is being received
//
//   Build option:
//     UART_SIM_RX_CONSOLE_EN  when defined, every received byte is echoed to the
//                             simulator console (CR suppressed). Not synthesizable.
module uart_sim_receiver_core #(
   parameter int unsigned CLOCK_FREQ = 100000000,
   parameter int unsigned BAUD_RATE  = 19200
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       txd_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       ferr_o,
   output logic       busy_o
);

   localparam int unsigned BitCyc = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned CntW   = $clog2(BitCyc) + 1;

   localparam logic [CntW-1:0] HalfLoad = CntW'(BitCyc / 2 - 1);
   localparam logic [CntW-1:0] FullLoad = CntW'(BitCyc - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   logic            sync1_q;
   logic            sync_q;
   logic            prev_q;
   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;

   logic cnt_zero;
   logic start_det;

   assign cnt_zero = (cnt_q == '0);
   // Sync and history FFs reset to 0, so a line held low out of reset never
   // looks like a falling edge until it has been seen high.
   assign start_det = prev_q & ~sync_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1_q  <= 1'b0;
         sync_q   <= 1'b0;
         prev_q   <= 1'b0;
         state_q  <= StIdle;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         shreg_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         sync1_q  <= txd_i;
         sync_q   <= sync1_q;
         prev_q   <= sync_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;

      case (state_q)
         StIdle: begin
            if (start_det) begin
               cnt_d   = HalfLoad;
               state_d = StStart;
            end
         end

         StStart: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!sync_q) begin
               cnt_d    = FullLoad;
               bitcnt_d = '0;
               state_d  = StData;
            end else begin
               // Line back high at mid start bit: a glitch, not a frame.
               state_d = StIdle;
            end
         end

         StData: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shreg_d  = {sync_q, shreg_q[7:1]};
               cnt_d    = FullLoad;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  state_d = StStop;
               end
            end
         end

         StStop: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if (sync_q) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
               // Leaving at mid stop bit lets a back-to-back start edge be caught.
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign ferr_o  = ferr_q;
   assign busy_o  = (state_q != StIdle);

`ifdef UART_SIM_RX_CONSOLE_EN
   always_ff @(posedge clk_i) begin
      if (valid_q && (data_q != 8'h0D)) begin
         $write("%c", data_q);
      end
   end
`endif

endmodule

// File: tb/tb_uart_sim_receiver_core.sv
// Bench for uart_sim_receiver_core with a short bit time (16 cycles/bit).
// Expected strobes are derived from the bytes the bench transmits; a monitor
// collects what the receiver reports and the two lists are compared.
module tb_uart_sim_receiver_core;

   localparam int unsigned ClockFreq = 1600000;
   localparam int unsigned BaudRate  = 100000;
   localparam int          BitCyc    = ClockFreq / BaudRate;
   localparam int          NomLat    = 2 + BitCyc / 2 + 9 * BitCyc;

   logic       clk;
   logic       rstn;
   logic       txd;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ferr_o;
   logic       busy_o;

   uart_sim_receiver_core #(
      .CLOCK_FREQ(ClockFreq),
      .BAUD_RATE (BaudRate)
   ) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .txd_i  (txd),
      .data_o (data_o),
      .valid_o(valid_o),
      .ferr_o (ferr_o),
      .busy_o (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event record: bit 8 = framing error, bits 7:0 = data_o at the strobe.
   logic [8:0] obs_q[$];
   logic [8:0] exp_q[$];
   int         last_ev_cyc = 0;
   int         both_hi = 0;
   int         start_cyc = 0;
   logic [7:0] data_exp = 8'h00;

   int n_chk  = 0;
   int n_fail = 0;

   always @(negedge clk) begin
      if (valid_o) begin
         obs_q.push_back({1'b0, data_o});
         last_ev_cyc = cyc;
      end
      if (ferr_o) begin
         obs_q.push_back({1'b1, data_o});
         last_ev_cyc = cyc;
      end
      if (valid_o && ferr_o) both_hi++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_events(input string tag);
      int n;
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
      end
      obs_q.delete();
      exp_q.delete();
      chk({tag, "_data"}, data_o, data_exp);
   endtask

   // Sends frame bits LSB first: bit0 start, bits 8:1 data, bit9 stop.
   task automatic send_bits(input logic [9:0] frame, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(posedge clk);
         #1 txd = frame[i];
         if (i == 0) start_cyc = cyc;
         repeat (BitCyc - 1) @(posedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      send_bits({stop_ok, b, 1'b0}, 10);
      exp_q.push_back({~stop_ok, stop_ok ? b : data_exp});
      if (stop_ok) data_exp = b;
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1 txd = 1'b1;
      repeat (n - 1) @(posedge clk);
   endtask

   logic [7:0] msg[7];
   logic [7:0] rb;
   logic       rok;
   int         lat;

   initial begin
      msg = '{8'h4E, 8'h45, 8'h4F, 8'h52, 8'h56, 8'h33, 8'h32};
      txd  = 1'b1;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", data_o, 8'h00);
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_ferr", ferr_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      rstn = 1'b1;
      idle(10);

      // 1: single byte, with latency from the falling edge
      send_byte(8'h4E, 1'b1);
      lat = last_ev_cyc - start_cyc;
      idle(5);
      chk("t1_latency_ok", (lat >= NomLat - 2) && (lat <= NomLat + 2), 1'b1);
      compare_events("t1");

      // 2: "NEORV32" back to back
      foreach (msg[i]) send_byte(msg[i], 1'b1);
      idle(5);
      compare_events("t2");

      // 3: short low glitch on an idle line
      idle(20);
      @(posedge clk);
      #1 txd = 1'b0;
      repeat (5) @(posedge clk);
      #1 txd = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("t3_busy_seen", busy_o, 1'b1);
      repeat (BitCyc) @(posedge clk);
      #1 chk("t3_busy_clear", busy_o, 1'b0);
      compare_events("t3");

      // 4: 0x55 with a low stop bit
      send_byte(8'h55, 1'b0);
      idle(10);
      compare_events("t4");

      // 5: reset during data bit 3, then 0xA5
      send_bits({1'b1, 8'h3C, 1'b0}, 4);
      repeat (BitCyc / 2) @(posedge clk);
      #1 chk("t5_busy_mid", busy_o, 1'b1);
      rstn = 1'b0;
      #1;
      chk("t5_rst_data", data_o, 8'h00);
      chk("t5_rst_valid", valid_o, 1'b0);
      chk("t5_rst_ferr", ferr_o, 1'b0);
      chk("t5_rst_busy", busy_o, 1'b0);
      txd = 1'b1;
      data_exp = 8'h00;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      idle(20);
      send_byte(8'hA5, 1'b1);
      idle(5);
      compare_events("t5");

      // 6: line held low through reset release
      @(posedge clk);
      #1 txd = 1'b0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      data_exp = 8'h00;
      repeat (2000) @(posedge clk);
      #1 chk("t6_busy_low", busy_o, 1'b0);
      compare_events("t6_low");
      idle(20);
      send_byte(8'h32, 1'b1);
      idle(5);
      compare_events("t6");

      // Random bytes, random gaps, some with bad stop bits
      for (int i = 0; i < 20; i++) begin
         rb  = 8'($urandom_range(0, 255));
         rok = ($urandom_range(0, 4) != 0);
         send_byte(rb, rok);
         if (!rok) idle($urandom_range(3, 20));
         else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
      end
      idle(10);
      compare_events("rnd");
      chk("never_both", both_hi, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
